// File: rtl/segway_pkg.sv
// rtl/segway_pkg.sv - shared state encoding and saturating ramp helpers for the drive sequencer
package segway_pkg;

  typedef enum logic [2:0] {
    OFF,
    RAMP_UP,
    BALANCE,
    STEER,
    FAULT,
    RAMP_DN
  } seq_state_t;

  localparam logic [7:0] SS_MAX = 8'hFF;

  function automatic logic [7:0] sat_up(input logic [7:0] cur, input logic [7:0] step);
    logic [8:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    return (sum > {1'b0, SS_MAX}) ? SS_MAX : sum[7:0];
  endfunction

  // bit 8 of the 9-bit difference is the borrow, i.e. the step went below zero
  function automatic logic [7:0] sat_dn(input logic [7:0] cur, input logic [7:0] step,
                                        input logic [7:0] lim);
    logic [8:0] diff;
    diff = {1'b0, cur} - {1'b0, step};
    return (diff[8] || (diff[7:0] < lim)) ? lim : diff[7:0];
  endfunction

endpackage

// File: rtl/segway_vld_cnt.sv
// rtl/segway_vld_cnt.sv - 10-bit strobe-qualified counter with sync clear and terminal-hit flag
module segway_vld_cnt #(
  parameter logic [9:0] TERM = 10'd1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  logic [9:0] count;

  // hit flags the increment that would make the count reach TERM
  assign hit = inc && (count == TERM - 10'd1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= 10'd0;
    end else if (inc) begin
      count <= count + 10'd1;
    end
  end

endmodule

// File: rtl/segway_drive_seq.sv
// rtl/segway_drive_seq.sv - power/soft-start sequencer producing pwr_up, ss_tmr and en_steer
module segway_drive_seq
  import segway_pkg::*;
#(
  parameter logic [7:0] SS_STEP      = 8'd1,
  parameter logic [9:0] SETTLE_TICKS = 10'd512,
  parameter logic [9:0] FAULT_HOLD   = 10'd64,
  parameter logic [7:0] FAULT_FLOOR  = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwr_req,
  input  logic       vld,
  input  logic       rider_ok,
  input  logic       steer_ok,
  input  logic       too_fast,
  output logic       pwr_up,
  output logic [7:0] ss_tmr,
  output logic       en_steer,
  output logic       clr_integ,
  output logic       fault
);

  seq_state_t state, state_nxt;
  logic [7:0] ss_nxt;
  logic       settle_inc, settle_clr, settle_hit;
  logic       hold_inc, hold_clr, hold_hit;

  assign settle_inc = (state == BALANCE) && vld && rider_ok && steer_ok;
  assign settle_clr = (state != BALANCE) || !rider_ok || !steer_ok || settle_hit;
  assign hold_inc   = (state == FAULT) && vld && !too_fast;
  assign hold_clr   = (state != FAULT) || too_fast || hold_hit;

  segway_vld_cnt #(.TERM(SETTLE_TICKS)) u_settle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (settle_clr),
    .inc (settle_inc),
    .hit (settle_hit)
  );

  segway_vld_cnt #(.TERM(FAULT_HOLD)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .clr (hold_clr),
    .inc (hold_inc),
    .hit (hold_hit)
  );

  // ramp step is taken by the current state; the transition below sees the stepped value
  always_comb begin
    ss_nxt = ss_tmr;
    case (state)
      OFF:            ss_nxt = 8'd0;
      RAMP_UP:        if (vld) ss_nxt = sat_up(ss_tmr, SS_STEP);
      BALANCE, STEER: ss_nxt = SS_MAX;
      FAULT:          if (vld && (ss_tmr > FAULT_FLOOR)) ss_nxt = sat_dn(ss_tmr, SS_STEP, FAULT_FLOOR);
      RAMP_DN:        if (vld) ss_nxt = sat_dn(ss_tmr, SS_STEP, 8'd0);
      default:        ss_nxt = 8'd0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (state == OFF) begin
      if (pwr_req) state_nxt = RAMP_UP;
    end else if (state == RAMP_DN) begin
      if (pwr_req)             state_nxt = RAMP_UP;
      else if (ss_nxt == 8'd0) state_nxt = OFF;
    end else if (!pwr_req) begin
      state_nxt = RAMP_DN;
    end else if (too_fast) begin
      state_nxt = FAULT;
    end else begin
      case (state)
        RAMP_UP: if (ss_nxt == SS_MAX) state_nxt = BALANCE;
        BALANCE: if (settle_hit) state_nxt = STEER;
        STEER:   if (!rider_ok || !steer_ok) state_nxt = BALANCE;
        FAULT:   if (hold_hit) state_nxt = RAMP_UP;
        default: state_nxt = OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= OFF;
      ss_tmr    <= 8'd0;
      pwr_up    <= 1'b0;
      en_steer  <= 1'b0;
      clr_integ <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      ss_tmr    <= ss_nxt;
      pwr_up    <= (state_nxt != OFF);
      en_steer  <= (state_nxt == STEER);
      clr_integ <= (state == OFF) && pwr_req;
      fault     <= (state_nxt == FAULT);
    end
  end

endmodule

// File: tb/tb_segway_drive_seq.sv
// tb/tb_segway_drive_seq.sv - scoreboard bench for segway_drive_seq with directed vld-strobe vectors
module tb_segway_drive_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwr_req = 1'b0;
  logic       vld = 1'b0;
  logic       rider_ok = 1'b0;
  logic       steer_ok = 1'b0;
  logic       too_fast = 1'b0;
  logic       pwr_up, en_steer, clr_integ, fault;
  logic [7:0] ss_tmr;

  typedef struct {
    string      tag;
    logic [7:0] ss;
    logic       pu;
    logic       es;
    logic       f;
    int         ci;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ci_cnt = 0;
  logic vld_q = 1'b0;

  always #5 clk = ~clk;

  segway_drive_seq #(
    .SS_STEP      (8'd8),
    .SETTLE_TICKS (10'd4),
    .FAULT_HOLD   (10'd3),
    .FAULT_FLOOR  (8'h80)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pwr_req   (pwr_req),
    .vld       (vld),
    .rider_ok  (rider_ok),
    .steer_ok  (steer_ok),
    .too_fast  (too_fast),
    .pwr_up    (pwr_up),
    .ss_tmr    (ss_tmr),
    .en_steer  (en_steer),
    .clr_integ (clr_integ),
    .fault     (fault)
  );

  always @(posedge clk) vld_q <= vld;

  // one observation per vld strobe; clr_integ pulses are tallied between observations
  always @(negedge clk) begin
    exp_t e;
    if (clr_integ === 1'b1) ci_cnt++;
    if (vld_q) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: got ss_tmr=%0d with no expected entry", ss_tmr);
      end else begin
        e = sb.pop_front();
        if ({ss_tmr, pwr_up, en_steer, fault} !== {e.ss, e.pu, e.es, e.f} || ci_cnt != e.ci) begin
          n_err++;
          $display("FAIL %s: got ss_tmr=%0d pwr_up=%b en_steer=%b fault=%b clr_integ_pulses=%0d, want %0d %b %b %b %0d",
                   e.tag, ss_tmr, pwr_up, en_steer, fault, ci_cnt, e.ss, e.pu, e.es, e.f, e.ci);
        end
      end
      ci_cnt = 0;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input string tag, input logic [7:0] ss, input logic pu,
                        input logic es, input logic f, input int ci);
    exp_t e;
    e.tag = tag; e.ss = ss; e.pu = pu; e.es = es; e.f = f; e.ci = ci;
    sb.push_back(e);
    vld = 1'b1;
    @(posedge clk);
    #1;
    vld = 1'b0;
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    strobe("reset", 8'd0, 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b0;

    // power up: OFF step holds 0, then 8 per strobe, saturating at 255
    pwr_req = 1'b1;
    strobe("pwrup_a", 8'd0, 1'b1, 1'b0, 1'b0, 1);
    for (int k = 1; k <= 31; k++) strobe("ramp_a", 8'(8 * k), 1'b1, 1'b0, 1'b0, 0);
    strobe("ramp_a_top", 8'd255, 1'b1, 1'b0, 1'b0, 0);

    // settle with a break at the third strobe
    rider_ok = 1'b1; steer_ok = 1'b1;
    for (int k = 0; k < 2; k++) strobe("settle", 8'd255, 1'b1, 1'b0, 1'b0, 0);
    steer_ok = 1'b0;
    strobe("settle_break", 8'd255, 1'b1, 1'b0, 1'b0, 0);
    steer_ok = 1'b1;
    for (int k = 0; k < 3; k++) strobe("settle_re", 8'd255, 1'b1, 1'b0, 1'b0, 0);
    strobe("steer_on", 8'd255, 1'b1, 1'b1, 1'b0, 0);

    rider_ok = 1'b0;
    strobe("steer_drop", 8'd255, 1'b1, 1'b0, 1'b0, 0);
    rider_ok = 1'b1;
    for (int k = 0; k < 3; k++) strobe("resettle", 8'd255, 1'b1, 1'b0, 1'b0, 0);
    strobe("resteer", 8'd255, 1'b1, 1'b1, 1'b0, 0);

    // overspeed: derate to the floor, hold count broken once, then exit
    too_fast = 1'b1;
    strobe("fault_entry", 8'd255, 1'b1, 1'b0, 1'b1, 0);
    for (int k = 1; k <= 15; k++) strobe("fault_ramp", 8'(255 - 8 * k), 1'b1, 1'b0, 1'b1, 0);
    strobe("fault_floor", 8'd128, 1'b1, 1'b0, 1'b1, 0);
    strobe("floor_hold", 8'd128, 1'b1, 1'b0, 1'b1, 0);
    too_fast = 1'b0;
    for (int k = 0; k < 2; k++) strobe("hold_cnt", 8'd128, 1'b1, 1'b0, 1'b1, 0);
    too_fast = 1'b1;
    strobe("hold_break", 8'd128, 1'b1, 1'b0, 1'b1, 0);
    too_fast = 1'b0;
    for (int k = 0; k < 2; k++) strobe("hold_cnt2", 8'd128, 1'b1, 1'b0, 1'b1, 0);
    strobe("fault_exit", 8'd128, 1'b1, 1'b0, 1'b0, 0);
    strobe("fault_resume", 8'd136, 1'b1, 1'b0, 1'b0, 0);

    // release at 40 with overspeed pulses ignored during the ramp down
    rst = 1'b1; pwr_req = 1'b0; rider_ok = 1'b0; steer_ok = 1'b0;
    strobe("reset_b", 8'd0, 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b0;
    pwr_req = 1'b1;
    strobe("pwrup_b", 8'd0, 1'b1, 1'b0, 1'b0, 1);
    for (int k = 1; k <= 5; k++) strobe("ramp_b", 8'(8 * k), 1'b1, 1'b0, 1'b0, 0);
    pwr_req = 1'b0;
    idle(2);
    for (int k = 4; k >= 1; k--) begin
      too_fast = k[0] ? 1'b0 : 1'b1;
      strobe("ramp_dn", 8'(8 * k), 1'b1, 1'b0, 1'b0, 0);
    end
    too_fast = 1'b1;
    strobe("ramp_dn_off", 8'd0, 1'b0, 1'b0, 1'b0, 0);
    too_fast = 1'b0;

    // re-request mid ramp-down resumes from 16 without clearing the integrator
    pwr_req = 1'b1;
    strobe("pwrup_c", 8'd0, 1'b1, 1'b0, 1'b0, 1);
    for (int k = 1; k <= 5; k++) strobe("ramp_c", 8'(8 * k), 1'b1, 1'b0, 1'b0, 0);
    pwr_req = 1'b0;
    idle(2);
    for (int k = 4; k >= 2; k--) strobe("ramp_dn_c", 8'(8 * k), 1'b1, 1'b0, 1'b0, 0);
    pwr_req = 1'b1;
    idle(2);
    strobe("resume", 8'd24, 1'b1, 1'b0, 1'b0, 0);
    for (int k = 4; k <= 31; k++) strobe("ramp_c2", 8'(8 * k), 1'b1, 1'b0, 1'b0, 0);
    strobe("ramp_c_top", 8'd255, 1'b1, 1'b0, 1'b0, 0);
    rider_ok = 1'b1; steer_ok = 1'b1;
    for (int k = 0; k < 3; k++) strobe("settle_c", 8'd255, 1'b1, 1'b0, 1'b0, 0);
    strobe("steer_c", 8'd255, 1'b1, 1'b1, 1'b0, 0);

    // reset in STEER with vld high
    rst = 1'b1; pwr_req = 1'b0;
    strobe("rst_steer", 8'd0, 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b0;
    strobe("off_hold", 8'd0, 1'b0, 1'b0, 1'b0, 0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
